// File: rtl/gan_layer_sequencer.sv
// Run controller for the generator's chain of MAC layers: launches each layer in
// turn, waits for its done, and reports completion, busy-cycle count and watchdog faults.
module gan_layer_sequencer #(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int CNT_W          = 20,
  parameter int IDX_W          = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [IDX_W-1:0]      layer_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      fault_layer,
  output logic [CNT_W-1:0]      total_cycles
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LAYERS - 1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] timer_r;
  logic [IDX_W-1:0] next_idx_s;
  logic             done_hit_s;

  assign next_idx_s = layer_idx + IDX_W'(1);
  assign done_hit_s = layer_done[layer_idx];

  // Sequencer state, registered outputs, watchdog timer and saturating busy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      timer_r      <= {CNT_W{1'b0}};
      layer_start  <= {NUM_LAYERS{1'b0}};
      layer_idx    <= {IDX_W{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      fault_layer  <= {IDX_W{1'b0}};
      total_cycles <= {CNT_W{1'b0}};
    end else begin
      layer_start <= {NUM_LAYERS{1'b0}};
      done        <= 1'b0;
      if (busy && (total_cycles != CNT_MAX)) begin
        total_cycles <= total_cycles + CNT_W'(1);
      end
      case (state_r)
        S_IDLE: begin
          // abort outranks a simultaneous start
          if (start && !abort) begin
            state_r      <= S_LAUNCH;
            layer_idx    <= {IDX_W{1'b0}};
            busy         <= 1'b1;
            error        <= 1'b0;
            total_cycles <= {CNT_W{1'b0}};
            layer_start  <= NUM_LAYERS'(1'b1);
          end
        end
        S_LAUNCH: begin
          if (abort) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= S_WAIT;
            timer_r <= {CNT_W{1'b0}};
          end
        end
        S_WAIT: begin
          if (abort) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else if (done_hit_s) begin
            if (layer_idx != LAST_IDX) begin
              state_r     <= S_LAUNCH;
              layer_idx   <= next_idx_s;
              layer_start <= NUM_LAYERS'(1'b1) << next_idx_s;
            end else begin
              state_r <= S_FINISH;
              done    <= 1'b1;
              busy    <= 1'b0;
            end
          end else if (timer_r == TIMER_LAST) begin
            state_r     <= S_IDLE;
            error       <= 1'b1;
            fault_layer <= layer_idx;
            busy        <= 1'b0;
          end else begin
            timer_r <= timer_r + CNT_W'(1);
          end
        end
        S_FINISH: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gan_layer_sequencer.sv
// Bench for gan_layer_sequencer: behavioural layer models plus a scoreboard of
// expected start pulses and expected completion cycle counts.
module tb_gan_layer_sequencer;

  localparam int NL = 3;
  localparam int IW = 2;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NL-1:0] layer_done;
  logic [NL-1:0] layer_start;
  logic [IW-1:0] layer_idx;
  logic          busy, done, error;
  logic [IW-1:0] fault_layer;
  logic [CW-1:0] total_cycles;

  logic [NL-1:0] model_done = '0;
  logic [NL-1:0] extra_done = '0;
  int            delay [NL];
  int            cnt   [NL];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_starts[$];
  int exp_done[$];
  logic prev_busy = 1'b0;

  assign layer_done = model_done | extra_done;

  gan_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(100), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .layer_done(layer_done),
    .layer_start(layer_start), .layer_idx(layer_idx), .busy(busy), .done(done),
    .error(error), .fault_layer(fault_layer), .total_cycles(total_cycles)
  );

  always #5 clk = ~clk;

  // Layer models: done pulses delay[i] cycles after the start-pulse cycle (0 = never)
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      model_done[i] = 1'b0;
      if (rst) begin
        cnt[i] = 0;
      end else begin
        if (cnt[i] > 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) model_done[i] = 1'b1;
        end
        if (layer_start[i] && delay[i] > 0) cnt[i] = delay[i];
      end
    end
  end

  // Scoreboard monitor: every start pulse and done pulse must match a queued expectation
  always @(negedge clk) begin
    if (layer_start != '0) begin
      n_checks++;
      if (exp_starts.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_start: layer_start=%b, required none", layer_start);
      end else begin
        int e;
        logic [NL-1:0] oh;
        e = exp_starts.pop_front();
        oh = '0;
        oh[e] = 1'b1;
        if (layer_start !== oh || layer_idx !== IW'(e)) begin
          n_fail++;
          $display("FAIL start_order: layer_start=%b idx=%0d, required %b idx=%0d", layer_start, layer_idx, oh, e);
        end
      end
    end
    if (done === 1'b1) begin
      n_checks++;
      if (exp_done.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done=1 total=%0d, required no done", total_cycles);
      end else begin
        int et;
        et = exp_done.pop_front();
        if (total_cycles !== CW'(et) || busy !== 1'b0 || prev_busy !== 1'b1 || error !== 1'b0) begin
          n_fail++;
          $display("FAIL done_cycle: total=%0d busy=%b prev_busy=%b error=%b, required total=%0d busy=0 prev_busy=1 error=0",
                   total_cycles, busy, prev_busy, error, et);
        end
      end
    end
    prev_busy = busy;
  end

  task automatic set_delays(input int d0, input int d1, input int d2);
    delay[0] = d0; delay[1] = d1; delay[2] = d2;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_start(input int idx, input int bound, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (layer_start[idx] === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic check_queues(input string tag);
    n_checks++;
    if (exp_starts.size() != 0 || exp_done.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: pending starts=%0d dones=%0d, required 0 0", tag, exp_starts.size(), exp_done.size());
      exp_starts.delete();
      exp_done.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({layer_start, layer_idx, busy, done, error, fault_layer, total_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: start=%b idx=%0d busy=%b done=%b err=%b fl=%0d tot=%0d, required all 0",
               layer_start, layer_idx, busy, done, error, fault_layer, total_cycles);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || layer_start !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b start=%b, required 0 000", busy, layer_start);
    end
  endtask

  task automatic run_full(input string tag);
    bit seen;
    exp_starts.push_back(0); exp_starts.push_back(1); exp_starts.push_back(2);
    exp_done.push_back(63);
    pulse_start();
    n_checks++;
    if (layer_start !== 3'b001 || busy !== 1'b1 || layer_idx !== 2'd0 || error !== 1'b0 || total_cycles !== 20'd0) begin
      n_fail++;
      $display("FAIL %s_accept: start=%b busy=%b idx=%0d err=%b tot=%0d, required 001 1 0 0 0",
               tag, layer_start, busy, layer_idx, error, total_cycles);
    end
    wait_done(200, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done never rose, required done within 200 cycles", tag);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (layer_idx !== 2'd2 || total_cycles !== 20'd63 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold: idx=%0d tot=%0d busy=%b done=%b err=%b, required 2 63 0 0 0",
               tag, layer_idx, total_cycles, busy, done, error);
    end
    check_queues(tag);
  endtask

  task automatic test_normal_run();
    set_delays(10, 20, 30);
    run_full("normal");
  endtask

  task automatic test_timeout();
    bit seen;
    int waited;
    set_delays(10, 0, 30);
    exp_starts.push_back(0); exp_starts.push_back(1);
    pulse_start();
    wait_start(1, 100, seen);
    waited = 0;
    while (error !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited != 101) begin
      n_fail++;
      $display("FAIL timeout_latency: error after %0d cycles, required 101", waited);
    end
    n_checks++;
    if (error !== 1'b1 || fault_layer !== 2'd1 || busy !== 1'b0 || total_cycles !== 20'd112) begin
      n_fail++;
      $display("FAIL timeout_state: err=%b fl=%0d busy=%b tot=%0d, required 1 1 0 112", error, fault_layer, busy, total_cycles);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || fault_layer !== 2'd1) begin
      n_fail++;
      $display("FAIL error_sticky: err=%b fl=%0d, required 1 1", error, fault_layer);
    end
    check_queues("timeout");
    set_delays(10, 20, 30);
    run_full("recover");
  endtask

  task automatic test_abort();
    bit seen;
    set_delays(10, 20, 30);
    exp_starts.push_back(0); exp_starts.push_back(1);
    pulse_start();
    wait_start(1, 100, seen);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || layer_start !== '0 || error !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_exit: busy=%b start=%b err=%b done=%b, required 0 000 0 0", busy, layer_start, error, done);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || total_cycles !== 20'd17 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after_late_done: busy=%b tot=%0d err=%b, required 0 17 0", busy, total_cycles, error);
    end
    // abort in IDLE together with start: nothing launches
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || layer_start !== '0 || total_cycles !== 20'd17) begin
      n_fail++;
      $display("FAIL start_abort_idle: busy=%b start=%b tot=%0d, required 0 000 17", busy, layer_start, total_cycles);
    end
    check_queues("abort");
  endtask

  task automatic test_collisions();
    bit seen;
    set_delays(10, 20, 30);
    exp_starts.push_back(0); exp_starts.push_back(1); exp_starts.push_back(2);
    exp_done.push_back(63);
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    extra_done = 3'b010;
    @(negedge clk);
    extra_done = 3'b000;
    wait_done(200, seen);
    start = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL collide_done_timeout: done never rose, required done within 200 cycles");
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || total_cycles !== 20'd63) begin
      n_fail++;
      $display("FAIL collide_total: busy=%b tot=%0d, required 0 63", busy, total_cycles);
    end
    check_queues("collide");
    // layer_done and abort in the same cycle
    exp_starts.push_back(0);
    pulse_start();
    wait_start(0, 10, seen);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || layer_start !== '0 || total_cycles !== 20'd11) begin
      n_fail++;
      $display("FAIL done_abort_same: busy=%b start=%b tot=%0d, required 0 000 11", busy, layer_start, total_cycles);
    end
    repeat (5) @(negedge clk);
    check_queues("done_abort");
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    set_delays(10, 20, 30);
    exp_starts.push_back(0); exp_starts.push_back(1); exp_starts.push_back(2);
    pulse_start();
    wait_start(2, 100, seen);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({layer_start, layer_idx, busy, done, error, fault_layer, total_cycles} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: start=%b idx=%0d busy=%b done=%b err=%b fl=%0d tot=%0d, required all 0",
               layer_start, layer_idx, busy, done, error, fault_layer, total_cycles);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_queues("reset_mid");
    run_full("after_reset");
  endtask

  initial begin
    set_delays(10, 20, 30);
    test_reset();
    test_normal_run();
    test_timeout();
    test_abort();
    test_collisions();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
